alu_4bit: RTL and testbench

- 4-bit arithmetic/logic unit with a registered 5-bit result (carry/borrow/shift-out in bit 4).
- Decodes a 3-bit opcode into 8 operations.
- Gated by an enable; holds its last result when disabled.
- Sits as the execution leaf in small datapaths; one-cycle latency from operands to result.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_4bit_core.sv | 34 +++
 rtl/alu_4bit.sv | 42 ++++
 tb/tb_alu_4bit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and operand width for the 4-bit ALU slice.
package alu_pkg;
  localparam int ALU_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;
endpackage

// File: rtl/alu_4bit_core.sv
// Combinational opcode decode and datapath; f carries carry/borrow/shift-out in its MSB.
module alu_4bit_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH:0]   f,
  output logic             zero
);
  logic [WIDTH:0] ax, bx;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  // SUB wraps in WIDTH+1 bits, so the MSB reads as a borrow whenever a < b.
  always_comb begin
    f = '0;
    case (alu_op_e'(opcode))
      ALU_ADD: f = ax + bx;
      ALU_SUB: f = ax - bx;
      ALU_AND: f = ax & bx;
      ALU_OR:  f = ax | bx;
      ALU_XOR: f = ax ^ bx;
      ALU_NOT: f = {1'b0, ~a};
      ALU_SHL: f = {a, 1'b0};
      ALU_SHR: f = {1'b0, a >> 1};
    endcase
  end

  assign zero = (f == '0);
endmodule

// File: rtl/alu_4bit.sv
// Enable-gated result register around the ALU core; one-cycle latency.
module alu_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             en,
  output logic [WIDTH:0]   result,
  output logic             valid,
  output logic             zero
);
  logic [WIDTH:0] f;
  logic           f_zero;

  alu_4bit_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .f      (f),
    .zero   (f_zero)
  );

  // Result and zero hold while disabled; valid only marks the cycle after a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        result <= f;
        zero   <= f_zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_4bit.sv
// Randomized and directed checks of alu_4bit against an arithmetic reference model.
module tb_alu_4bit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [2:0] opcode = '0;
  logic       en = 1'b0;
  logic [4:0] result;
  logic       valid;
  logic       zero;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_res = '0;
  logic       exp_zero = 1'b0;
  logic       exp_valid = 1'b0;

  alu_4bit dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .en     (en),
    .result (result),
    .valid  (valid),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the unsigned operand values.
  function automatic logic [4:0] ref_f(int op, int x, int y);
    int r;
    case (op)
      0: r = x + y;
      1: r = (x - y + 32) % 32;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 15 - x;
      6: r = x * 2;
      default: r = x / 2;
    endcase
    return 5'(r);
  endfunction

  // Advance one clock, update the model with what the DUT sampled, settle.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_res = '0; exp_zero = 1'b0; exp_valid = 1'b0;
    end else if (en) begin
      exp_res   = ref_f(int'(opcode), int'(a), int'(b));
      exp_zero  = (exp_res == 5'd0);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; a = 4'd2; b = 4'd3; opcode = 3'b000;
    tick(); tick();
    checks++;
    if (result !== 5'd0 || valid !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: result=%b valid=%b zero=%b, want 00000/0/0", result, valid, zero);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (result !== 5'b00101 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: result=%b valid=%b, want 00101/1", result, valid);
    end
    // Async assertion mid-cycle must clear outputs without waiting for an edge.
    rst = 1'b1;
    #1;
    exp_res = '0; exp_zero = 1'b0; exp_valid = 1'b0;
    checks++;
    if (result !== 5'd0 || valid !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: result=%b valid=%b zero=%b, want 00000/0/0", result, valid, zero);
    end
    tick();
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_hold();
    a = 4'd2; b = 4'd3;
    for (int op = 0; op < 8; op++) begin
      opcode = 3'(op);
      tick();
      checks++;
      if (result !== 5'd0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL hold op=%0d: result=%b valid=%b, want 00000/0", op, result, valid);
      end
    end
  endtask

  task automatic test_sweep();
    en = 1'b1; a = 4'b0010; b = 4'b0011;
    for (int op = 0; op < 8; op++) begin
      opcode = 3'(op);
      tick();
      checks++;
      if (result !== exp_res || zero !== exp_zero || valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep op=%0d: result=%b zero=%b valid=%b, want %b/%b/1",
                 op, result, zero, valid, exp_res, exp_zero);
      end
    end
  endtask

  task automatic test_boundaries();
    // {opcode, a, b, expected result}
    logic [16:0] vec [6];
    vec[0] = {3'b000, 4'd15, 4'd15, 5'b11110, 1'b0};
    vec[1] = {3'b001, 4'd0,  4'd15, 5'b10001, 1'b0};
    vec[2] = {3'b001, 4'd7,  4'd7,  5'b00000, 1'b1};
    vec[3] = {3'b110, 4'b1000, 4'd5, 5'b10000, 1'b0};
    vec[4] = {3'b111, 4'b0001, 4'd9, 5'b00000, 1'b1};
    vec[5] = {3'b101, 4'b1111, 4'd3, 5'b00000, 1'b1};
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [16:0] v;
      v = vec[i];
      opcode = v[16:14]; a = v[13:10]; b = v[9:6];
      tick();
      checks++;
      if (result !== v[5:1] || zero !== v[0] || valid !== 1'b1) begin
        errors++;
        $display("FAIL boundary %0d: result=%b zero=%b valid=%b, want %b/%b/1",
                 i, result, zero, valid, v[5:1], v[0]);
      end
    end
  endtask

  task automatic test_enable_toggle();
    en = 1'b1; a = 4'd2; b = 4'd3; opcode = 3'b000;
    tick();
    checks++;
    if (result !== 5'b00101 || valid !== 1'b1) begin
      errors++;
      $display("FAIL toggle_capture: result=%b valid=%b, want 00101/1", result, valid);
    end
    en = 1'b0; opcode = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (result !== 5'b00101 || valid !== 1'b0 || zero !== 1'b0) begin
        errors++;
        $display("FAIL toggle_hold %0d: result=%b valid=%b zero=%b, want 00101/0/0",
                 i, result, valid, zero);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en     = ($urandom_range(3) != 0);
      a      = 4'($urandom);
      b      = 4'($urandom);
      opcode = 3'($urandom);
      tick();
      checks++;
      if (result !== exp_res || zero !== exp_zero || valid !== exp_valid) begin
        errors++;
        $display("FAIL random %0d: result=%b zero=%b valid=%b, want %b/%b/%b",
                 i, result, zero, valid, exp_res, exp_zero, exp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_sweep();
    test_boundaries();
    test_enable_toggle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
